// File: rtl/svi_rr_arbiter_if.sv
// svi_rr_arbiter_if: one requester's link to the shared-resource arbiter.
//   req  - level request, driven by the requester
//   done - one-cycle release pulse, driven by the requester
//   gnt  - grant, driven only by the arbiter
// Modports: master (requester side), slave (arbiter side).
interface svi_rr_arbiter_if;
    logic req;
    logic done;
    logic gnt;

    modport master (output req, output done, input gnt);
    modport slave  (input req, input done, output gnt);
endinterface

// File: rtl/svi_rr_arbiter.sv
// svi_rr_arbiter: round-robin arbiter sharing one resource among N requester interfaces.
// Ports:
//   clk        - clock, rising edge
//   rst_n      - asynchronous active-low reset
//   u_A[N-1:0] - requester interface array (slave modport): req/done in, gnt out
//   o_owner    - index of the current grant holder, 0 when idle
//   o_busy     - high while any gnt is high
//   o_gnt_cnt  - grants issued since reset, saturating at 16'hFFFF
//   o_timeout  - sticky flag, set when a grant is revoked by the hold limit
// Optional feature: define ARB_TIMEOUT_EN to revoke grants held for MAX_HOLD cycles;
// without it o_timeout is tied low and grants are held until done or req drop.
module svi_rr_arbiter #(
    parameter int unsigned N        = 8,
    parameter int unsigned OW       = $clog2(N),
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    svi_rr_arbiter_if.slave         u_A [N-1:0],
    output logic [OW-1:0]           o_owner,
    output logic                    o_busy,
    output logic [15:0]             o_gnt_cnt,
    output logic                    o_timeout
);

    if (N < 2 || N > 16 || MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_param_check
        $error("svi_rr_arbiter: parameter out of range");
    end

    typedef enum logic {StIdle, StBusy} state_e;

    state_e          state_q;
    logic [N-1:0]    gnt_q;
    logic [OW-1:0]   owner_q;
    logic [OW-1:0]   ptr_q;
    logic [15:0]     cnt_q;

    logic [N-1:0]    req_vec;
    logic [N-1:0]    done_vec;
    logic [N-1:0]    win_oh;
    logic [OW-1:0]   winner;
    logic [OW-1:0]   next_ptr;
    logic            any_req;
    logic            user_rel;
    logic            release_now;

    for (genvar i = 0; i < N; i++) begin : g_port
        assign req_vec[i]  = u_A[i].req;
        assign done_vec[i] = u_A[i].done;
        assign u_A[i].gnt  = gnt_q[i];
    end

    // Walk offsets from the far end back to 0 so the smallest offset from ptr wins.
    always_comb begin
        int pos;
        winner  = '0;
        any_req = 1'b0;
        for (int k = int'(N) - 1; k >= 0; k--) begin
            pos = int'(ptr_q) + k;
            if (pos >= int'(N)) begin
                pos = pos - int'(N);
            end
            if (req_vec[pos]) begin
                winner  = OW'(pos);
                any_req = 1'b1;
            end
        end
        win_oh         = '0;
        win_oh[winner] = 1'b1;
        next_ptr       = (winner == OW'(N - 1)) ? '0 : winner + OW'(1);
    end

    // Only the holder's signals matter; gnt_q masks out everyone else.
    assign user_rel = |(done_vec & gnt_q) | ~|(req_vec & gnt_q);

`ifdef ARB_TIMEOUT_EN
    logic [7:0] hold_q;
    logic [7:0] hold_inc;
    logic       hold_exp;
    logic       timeout_q;

    assign hold_inc    = hold_q + 8'd1;
    assign hold_exp    = (hold_inc == 8'(MAX_HOLD));
    assign release_now = user_rel | hold_exp;
    assign o_timeout   = timeout_q;
`else
    assign release_now = user_rel;
    assign o_timeout   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            gnt_q     <= '0;
            owner_q   <= '0;
            ptr_q     <= '0;
            cnt_q     <= '0;
`ifdef ARB_TIMEOUT_EN
            hold_q    <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (any_req) begin
                        state_q <= StBusy;
                        gnt_q   <= win_oh;
                        owner_q <= winner;
                        ptr_q   <= next_ptr;
                        if (cnt_q != 16'hFFFF) begin
                            cnt_q <= cnt_q + 16'd1;
                        end
`ifdef ARB_TIMEOUT_EN
                        hold_q  <= '0;
`endif
                    end
                end
                StBusy: begin
                    if (release_now) begin
                        state_q <= StIdle;
                        gnt_q   <= '0;
                        owner_q <= '0;
                    end
`ifdef ARB_TIMEOUT_EN
                    hold_q <= hold_inc;
                    // A coincident done/req-drop wins: that is an ordinary release.
                    if (hold_exp && !user_rel) begin
                        timeout_q <= 1'b1;
                    end
`endif
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign o_owner   = owner_q;
    assign o_busy    = |gnt_q;
    assign o_gnt_cnt = cnt_q;

endmodule

// File: tb/tb_svi_rr_arbiter.sv
module tb_svi_rr_arbiter;
    localparam int N  = 8;
    localparam int MH = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  req_v = '0;
    logic [7:0]  done_v = '0;
    logic [7:0]  gnt_v;
    logic [2:0]  owner;
    logic        busy;
    logic [15:0] cnt;
    logic        to;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    svi_rr_arbiter_if u_A [7:0] ();

    for (genvar i = 0; i < N; i++) begin : g_req
        assign u_A[i].req  = req_v[i];
        assign u_A[i].done = done_v[i];
        assign gnt_v[i]    = u_A[i].gnt;
    end

    svi_rr_arbiter #(.N(N), .MAX_HOLD(MH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .u_A       (u_A),
        .o_owner   (owner),
        .o_busy    (busy),
        .o_gnt_cnt (cnt),
        .o_timeout (to)
    );

    // Reference model: owner (-1 = nobody), next search start, grant total, hold age.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_cnt   = 0;
    int m_hold  = 0;
    bit m_to    = 1'b0;

    function automatic void model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_cnt   = 0;
        m_hold  = 0;
        m_to    = 1'b0;
    endfunction

    function automatic void model_edge(input logic [7:0] r, input logic [7:0] d);
        bit rel;
        int idx;
        if (m_owner < 0) begin
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (r[idx]) begin
                    m_owner = idx;
                    m_ptr   = (idx + 1) % N;
                    if (m_cnt < 65535) m_cnt++;
                    m_hold  = 0;
                    break;
                end
            end
        end else begin
            rel = d[m_owner] || !r[m_owner];
`ifdef ARB_TIMEOUT_EN
            m_hold++;
            if (!rel && m_hold == MH) begin
                rel  = 1'b1;
                m_to = 1'b1;
            end
`endif
            if (rel) m_owner = -1;
        end
    endfunction

    function automatic logic [7:0] exp_gnt();
        return (m_owner < 0) ? 8'h00 : 8'(1 << m_owner);
    endfunction

    task automatic check(input string name, input logic [28:0] got, input logic [28:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic compare_model(input string name);
        check(name, {gnt_v, owner, busy, cnt, to},
              {exp_gnt(), 3'((m_owner < 0) ? 0 : m_owner), (m_owner >= 0), 16'(m_cnt), m_to});
    endtask

    // Drive one cycle of inputs, advance model and DUT, then compare.
    task automatic cyc(input logic [7:0] r, input logic [7:0] d, input string name);
        req_v  = r;
        done_v = d;
        model_edge(r, d);
        @(posedge clk);
        #1;
        compare_model(name);
    endtask

    typedef struct {
        logic [7:0]  req;
        logic [7:0]  done;
        logic [7:0]  gnt;
        logic [2:0]  owner;
        logic [15:0] cnt;
    } vec_t;

    vec_t tbl [16];
    int   hi2;
    int   gtime [$];
    int   gown [$];
    logic [7:0] r_rand;
    logic [7:0] d_rand;

    initial begin
        // Single requester 3, done after 4 grant cycles; then 5 drops req; then ptr=6 wrap.
        tbl[0]  = '{8'h08, 8'h00, 8'h08, 3'd3, 16'd1};
        tbl[1]  = '{8'h08, 8'h00, 8'h08, 3'd3, 16'd1};
        tbl[2]  = '{8'h08, 8'h00, 8'h08, 3'd3, 16'd1};
        tbl[3]  = '{8'h08, 8'h00, 8'h08, 3'd3, 16'd1};
        tbl[4]  = '{8'h08, 8'h08, 8'h00, 3'd0, 16'd1};
        tbl[5]  = '{8'h00, 8'h00, 8'h00, 3'd0, 16'd1};
        tbl[6]  = '{8'h20, 8'h00, 8'h20, 3'd5, 16'd2};
        tbl[7]  = '{8'h00, 8'h00, 8'h00, 3'd0, 16'd2};
        tbl[8]  = '{8'h42, 8'h00, 8'h40, 3'd6, 16'd3};
        tbl[9]  = '{8'h42, 8'h40, 8'h00, 3'd0, 16'd3};
        tbl[10] = '{8'h42, 8'h00, 8'h02, 3'd1, 16'd4};
        tbl[11] = '{8'h42, 8'h02, 8'h00, 3'd0, 16'd4};
        tbl[12] = '{8'h40, 8'h02, 8'h40, 3'd6, 16'd5};
        tbl[13] = '{8'h40, 8'h01, 8'h40, 3'd6, 16'd5};
        tbl[14] = '{8'h40, 8'h40, 8'h00, 3'd0, 16'd5};
        tbl[15] = '{8'h00, 8'h00, 8'h00, 3'd0, 16'd5};

        // Reset held with random requests.
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req_v = 8'($urandom);
            @(posedge clk);
            #1;
            check("reset_state", {gnt_v, owner, busy, cnt, to}, 29'd0);
        end
        req_v = '0;
        rst_n = 1'b1;
        model_reset();

        for (int i = 0; i < 16; i++) begin
            cyc(tbl[i].req, tbl[i].done, "tbl_model");
            check("tbl_vector", {2'b00, gnt_v, owner, cnt}, {2'b00, tbl[i].gnt, tbl[i].owner, tbl[i].cnt});
        end

        // Requester 2 never releases; requester 3 waits behind it.
        hi2 = 0;
        for (int i = 0; i < 22; i++) begin
            cyc(8'h0C, 8'h00, "hold_model");
            if (gnt_v[2]) hi2++;
        end
`ifdef ARB_TIMEOUT_EN
        check("hold_cycles", 29'(hi2), 29'd16);
        check("timeout_flag", {28'd0, to}, 29'd1);
        check("next_granted", {28'd0, gnt_v[3]}, 29'd1);
`else
        check("hold_cycles", 29'(hi2), 29'd22);
        check("timeout_flag", {28'd0, to}, 29'd0);
        check("next_granted", {28'd0, gnt_v[3]}, 29'd0);
`endif
        cyc(8'h00, 8'h00, "hold_release");
        cyc(8'h00, 8'h00, "hold_idle");

        // Reset while requester 7 holds the grant.
        cyc(8'h80, 8'h00, "pre_reset_grant");
        check("gnt7_held", {28'd0, gnt_v[7]}, 29'd1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async_reset", {gnt_v, owner, busy, cnt, to}, 29'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // All requesting, each holder pulses done in its first grant cycle.
        for (int c = 0; c < 34; c++) begin
            cyc(8'hFF, exp_gnt(), "rr_all_model");
            if (busy) begin
                gtime.push_back(c);
                gown.push_back(int'(owner));
            end
        end
        check("rr_grant_count", 29'(gtime.size()), 29'd17);
        for (int k = 0; k < 9 && k < gown.size(); k++) begin
            check("rr_order", 29'(gown[k]), 29'(k % 8));
            if (k > 0) check("rr_spacing", 29'(gtime[k] - gtime[k-1]), 29'd2);
        end
        cyc(8'h00, 8'h00, "rr_drain");

        // Random traffic against the model.
        r_rand = '0;
        for (int c = 0; c < 400; c++) begin
            r_rand = r_rand ^ (8'($urandom) & 8'($urandom));
            d_rand = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            cyc(r_rand, d_rand, "random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/svi_rr_arbiter.md
# svi_rr_arbiter

Round-robin arbiter that shares one downstream resource among an array of SystemVerilog interface instances. Each instance carries scalar request, grant and done members. The arbiter drives every grant member from a generate loop over the interface array. It sits between the requester array (instantiated in the top module) and the shared resource, and reports the current owner and grant statistics as top-level outputs.

## Interface
- `N`, 8, number of requester interface instances; legal range 2..16.
- `OW`, `$clog2(N)`, width of the owner index (derived; do not override).
- `MAX_HOLD`, 16, cycles a grant may be held before revocation; legal range 1..255; used only with `ARB_TIMEOUT_EN`.
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `u_A[N-1:0]`  interface array  N x 3 scalars  interface `A` has the following members:
  - `req`: driven by the requester; level request.
  - `done`: driven by the requester; one-cycle release pulse.
  - `gnt`: driven only by this block.
- `o_owner`  output  OW  index of the current grant holder; 0 when idle.
- `o_busy`  output  1  high while any `gnt` is high.
- `o_gnt_cnt`  output  16  total grants issued since reset; saturates at 16'hFFFF.
- `o_timeout`  output  1  sticky flag, set on any revocation.

## Operation
- States:
  - IDLE: no grant held.
  - BUSY: exactly one `gnt` is high.
- Round-robin pointer `ptr` (OW bits):
  - Holds the first index to search; 0 at reset.
  - After granting index k, `ptr` becomes (k+1) mod N; wraps from N-1 to 0.
- IDLE:
  - If any `u_A[i].req` is sampled high, pick the first requesting index found when searching `ptr`, `ptr+1`, ... modulo N.
  - Then register `gnt[winner]` = 1, set `o_owner` = winner, increment `o_gnt_cnt` and go to BUSY.
  - If no request is sampled high, stay in IDLE.
- BUSY, the holder is released on the edge that samples any of:
  - `done` high;
  - `req` low;
  - with `ARB_TIMEOUT_EN`, the hold counter reaching `MAX_HOLD`.
- On release: clear `gnt`, set `o_owner` to 0, return to IDLE.
- Requests from non-holders are ignored while in BUSY; they are arbitrated on the next IDLE cycle.
- One-hot invariant: at most one `gnt` is high in any cycle. `o_busy` is the OR of all `gnt` members.
- `o_gnt_cnt` does not wrap: increments are suppressed at 16'hFFFF.
- `done` asserted by a non-holder, or asserted in IDLE, has no effect.
- Reset values (asynchronous):
  - all `gnt` = 0, `o_owner` = 0, `o_busy` = 0, `o_gnt_cnt` = 0, `o_timeout` = 0;
  - `ptr` = 0, state = IDLE, hold counter = 0.
- Reset asserted mid-grant drops `gnt` immediately, without waiting for a clock edge.

## Timing
- Grant latency:
  - `gnt` rises on the first edge that samples `req` high in IDLE.
  - The arbitration decision is combinational from the sampled `req` values; `gnt` is registered.
- Release:
  - `gnt` falls on the edge that samples the release condition.
  - The next grant comes no earlier than the following edge, so there is at least one cycle with all `gnt` low between owners.
- Back-to-back: with all N requesters holding `req` and each pulsing `done` one cycle after its grant, each grant lasts 1 cycle. This gives 2 cycles per owner.
- Simultaneous `done` and timeout on the same edge: treat as one release; `o_timeout` is not set.
- `o_owner`, `o_busy` and `o_gnt_cnt` update on the same edge as `gnt`.
- Requesters must hold `req` until granted. A `req` pulse that falls before the sampling edge is lost.

## Configuration
- `ARB_TIMEOUT_EN` defined:
  - An 8-bit hold counter clears on grant and increments each BUSY cycle.
  - When it equals `MAX_HOLD`, the grant is revoked on that edge and `o_timeout` is set (sticky until reset).
  - The revoked requester loses priority through normal pointer advance.
- `ARB_TIMEOUT_EN` undefined: no hold counter, grants are held indefinitely until `done` or `req` drop, and `o_timeout` is tied to 0.

## Test plan
- Reset: hold `rst_n` = 0 with random `req` -> all `gnt` = 0, `o_owner` = 0, `o_gnt_cnt` = 0, `o_busy` = 0.
- Single requester: `u_A[3].req` = 1, `done` pulsed 4 cycles after the grant -> `gnt[3]` rises on the first sampling edge and lasts 4 cycles; `o_owner` = 3; `o_gnt_cnt` = 1; next `ptr` = 4.
- Contention with wrap: `ptr` = 6 and requesters 1 and 6 active -> grant order is 6 then 1; with all 8 active the order is 0,1,...,7,0, with one idle gap between owners.
- Release by req drop: holder 5 drops `req` without `done` -> `gnt[5]` falls on that edge and `o_busy` = 0 for 1 cycle.
- Timeout (macro on, `MAX_HOLD` = 16): requester 2 holds `req` and never pulses `done` -> `gnt[2]` falls after 16 BUSY cycles, `o_timeout` = 1, and the next requester is granted. With the macro off, the same stimulus keeps the grant indefinitely and `o_timeout` = 0.
- Reset mid-grant: assert `rst_n` = 0 while `gnt[7]` = 1 -> `gnt[7]` drops asynchronously, `ptr` = 0 after reset, and the first post-reset grant goes to the lowest-index requester.
